// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll controller.
package dice_pkg;

    localparam int unsigned FACE_W     = 3;
    localparam int unsigned LFSR_W     = 8;
    localparam int unsigned ROLL_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPIN   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [FACE_W-1:0] FACE_MIN = 3'd1;
    localparam logic [FACE_W-1:0] FACE_MAX = 3'd6;

    // x^8+x^6+x^5+x^4+1 expressed as the register bits XORed into the feedback
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dice_roll_ctrl_if.sv
// Requester/counter-side signals of the dice roll controller.
interface dice_roll_ctrl_if;
    import dice_pkg::*;

    logic                  roll_req;
    logic                  result_ack;
    logic [FACE_W-1:0]     num_in;
    logic                  cnt_en;
    logic [FACE_W-1:0]     result;
    logic                  result_valid;
    logic                  result_err;
    logic                  busy;
    logic [ROLL_CNT_W-1:0] roll_cnt;

    modport master (
        output roll_req, result_ack, num_in,
        input  cnt_en, result, result_valid, result_err, busy, roll_cnt
    );

    modport slave (
        input  roll_req, result_ack, num_in,
        output cnt_en, result, result_valid, result_err, busy, roll_cnt
    );
endinterface

// File: rtl/dice_lfsr.sv
// Free-running 8-bit Fibonacci LFSR supplying the random spin extension.
module dice_lfsr
    import dice_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Spins the dice counter for a pseudo-random number of cycles, then captures
// and holds the face until the consumer acknowledges it.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int unsigned       MIN_SPIN     = 8,
    parameter int unsigned       SPIN_RANGE_W = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
    input logic             clk,
    input logic             reset,
    dice_roll_ctrl_if.slave bus
);

    localparam int unsigned SPIN_W = $clog2(MIN_SPIN + 2**SPIN_RANGE_W) + 1;

    state_t                state, state_nxt;
    logic [SPIN_W-1:0]     spin_cnt, spin_cnt_nxt;
    logic                  cnt_en_r, cnt_en_nxt;
    logic [FACE_W-1:0]     result_r, result_nxt;
    logic                  valid_r, valid_nxt;
    logic                  err_r, err_nxt;
    logic                  busy_r, busy_nxt;
    logic [ROLL_CNT_W-1:0] roll_cnt_r, roll_cnt_nxt;

    logic [LFSR_W-1:0]     lfsr;
    logic [SPIN_W-1:0]     spin_load;
    logic                  lfsr_unused;

    dice_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    // only the low bits set the spin length; the rest just keep the sequence long
    assign lfsr_unused = ^lfsr;
    assign spin_load   = SPIN_W'(MIN_SPIN) + SPIN_W'(lfsr[SPIN_RANGE_W-1:0]);

    // state and datapath registers; async reset aborts any roll immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            spin_cnt   <= '0;
            cnt_en_r   <= 1'b0;
            result_r   <= '0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            roll_cnt_r <= '0;
        end else begin
            state      <= state_nxt;
            spin_cnt   <= spin_cnt_nxt;
            cnt_en_r   <= cnt_en_nxt;
            result_r   <= result_nxt;
            valid_r    <= valid_nxt;
            err_r      <= err_nxt;
            busy_r     <= busy_nxt;
            roll_cnt_r <= roll_cnt_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.roll_req)               state_nxt = SPIN;
            SPIN:    if (spin_cnt == SPIN_W'(1))     state_nxt = SETTLE;
            SETTLE:                                  state_nxt = DONE;
            DONE:    if (bus.result_ack)             state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // next values of the registered outputs and the spin counter
    always_comb begin
        spin_cnt_nxt = spin_cnt;
        cnt_en_nxt   = cnt_en_r;
        result_nxt   = result_r;
        valid_nxt    = valid_r;
        err_nxt      = err_r;
        busy_nxt     = busy_r;
        roll_cnt_nxt = roll_cnt_r;
        case (state)
            IDLE: begin
                if (bus.roll_req) begin
                    spin_cnt_nxt = spin_load;
                    cnt_en_nxt   = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            SPIN: begin
                if (spin_cnt == SPIN_W'(1)) begin
                    cnt_en_nxt = 1'b0;
                end
                spin_cnt_nxt = spin_cnt - SPIN_W'(1);
            end
            SETTLE: begin
                result_nxt   = bus.num_in;
                err_nxt      = (bus.num_in < FACE_MIN) || (bus.num_in > FACE_MAX);
                valid_nxt    = 1'b1;
                roll_cnt_nxt = (roll_cnt_r == '1) ? roll_cnt_r
                                                  : roll_cnt_r + ROLL_CNT_W'(1);
            end
            DONE: begin
                if (bus.result_ack) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                spin_cnt_nxt = '0;
                cnt_en_nxt   = 1'b0;
                valid_nxt    = 1'b0;
                busy_nxt     = 1'b0;
            end
        endcase
    end

    assign bus.cnt_en       = cnt_en_r;
    assign bus.result       = result_r;
    assign bus.result_valid = valid_r;
    assign bus.result_err   = err_r;
    assign bus.busy         = busy_r;
    assign bus.roll_cnt     = roll_cnt_r;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Randomized scoreboard bench for dice_roll_ctrl driving a behavioural 1..6 dice counter.
module tb_dice_roll_ctrl;

    localparam int MIN_SPIN = 8;
    localparam int RANGE    = 16;

    typedef struct {
        int len;
        int face;
        int err;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic force_zero = 1'b0;
    logic [2:0] num;
    logic [7:0] m_lfsr;

    int checks = 0;
    int failures = 0;
    int n_rolls = 0;
    int range_bad = 0;
    exp_t exp_q[$];
    bit seen_len[0:63];

    dice_roll_ctrl_if bus ();

    dice_roll_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // dice counter: cycles 1..6 while enabled
    always @(posedge clk or posedge reset) begin
        if (reset)           num <= 3'd1;
        else if (bus.cnt_en) num <= (num == 3'd6) ? 3'd1 : num + 3'd1;
    end
    assign bus.num_in = force_zero ? 3'd0 : num;

    // reference LFSR: x^8+x^6+x^5+x^4+1, stepped once per clock out of reset
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.len = MIN_SPIN + int'(m_lfsr[3:0]);
        e.face = force_zero ? 0 : ((int'(bus.num_in) - 1 + e.len) % 6) + 1;
        e.err = force_zero ? 1 : 0;
        n_rolls++;
        e.cnt = (n_rolls > 255) ? 255 : n_rolls;
        return e;
    endfunction

    // one complete roll: request, wait for the result, acknowledge
    task automatic do_roll(input bit hold, input bit ack_req);
        bit got;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp_q.push_back(predict());
        bus.roll_req = 1'b1;
        @(negedge clk);
        if (!hold) bus.roll_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (bus.result_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) check("result_valid_timeout", 0, 1);
        bus.roll_req = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.result_ack = 1'b1;
        if (ack_req) bus.roll_req = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        bus.roll_req = 1'b0;
        check("after_ack_en_valid_busy", {bus.cnt_en, bus.result_valid, bus.busy}, 0);
        if (ack_req) begin
            @(negedge clk);
            check("no_spin_from_done_req", bus.cnt_en, 0);
        end
    endtask

    // monitor: measures each cnt_en pulse and checks every captured result
    initial begin
        int en_len = 0;
        int last_len = 0;
        int since_fall = 0;
        bit prev_en = 0;
        bit prev_valid = 0;
        bit in_roll = 0;
        bit busy_ok = 1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_len = 0; prev_en = 0; prev_valid = 0; in_roll = 0; busy_ok = 1; since_fall = 0;
            end else begin
                if (bus.cnt_en && !prev_en) begin
                    in_roll = 1; busy_ok = 1; en_len = 0;
                    if (exp_q.size() == 0) check("unexpected_spin", 1, 0);
                end
                if (bus.cnt_en) en_len++;
                if (!bus.cnt_en && prev_en) begin
                    last_len = en_len;
                    since_fall = 0;
                end else if (since_fall < 1000) begin
                    since_fall++;
                end
                if (in_roll && !bus.busy) busy_ok = 0;
                if (bus.result_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("valid_without_request", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("spin_len", last_len, e.len);
                        check("valid_after_en_fall", since_fall, 1);
                        check("result", int'(bus.result), e.face);
                        check("result_err", int'(bus.result_err), e.err);
                        check("roll_cnt", int'(bus.roll_cnt), e.cnt);
                        check("busy_through_roll", int'(busy_ok), 1);
                        if (last_len < MIN_SPIN || last_len > MIN_SPIN + RANGE - 1) range_bad++;
                        if (last_len >= 0 && last_len < 64) seen_len[last_len] = 1'b1;
                    end
                    in_roll = 0;
                end
                prev_en = bus.cnt_en;
                prev_valid = bus.result_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int distinct;
        bus.roll_req = 1'b0;
        bus.result_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.cnt_en, bus.result, bus.result_valid, bus.result_err, bus.busy, bus.roll_cnt}, 0);
        reset = 1'b0;
        #1 check("lfsr_seed", int'(dut.u_lfsr.q), 8'hA5);

        // single pulses, held request, ack coinciding with request
        for (int i = 0; i < 4; i++) do_roll(1'b0, 1'b0);
        do_roll(1'b1, 1'b0);
        do_roll(1'b0, 1'b1);
        do_roll(1'b0, 1'b0);

        // counter disconnected: illegal face captured
        force_zero = 1'b1;
        do_roll(1'b0, 1'b0);
        force_zero = 1'b0;

        // reset in the middle of a spin
        @(negedge clk);
        exp_q.push_back(predict());
        bus.roll_req = 1'b1;
        @(negedge clk);
        bus.roll_req = 1'b0;
        repeat (4) @(negedge clk);
        check("spinning_before_reset", bus.cnt_en, 1);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs",
                 {bus.cnt_en, bus.result, bus.result_valid, bus.result_err, bus.busy, bus.roll_cnt}, 0);
        exp_q.delete();
        n_rolls = 0;
        @(negedge clk);
        reset = 1'b0;
        #1 check("lfsr_seed_after_reset", int'(dut.u_lfsr.q), 8'hA5);

        // back-to-back rolls through roll_cnt saturation
        for (int i = 0; i < 300; i++) do_roll(1'b0, 1'b0);
        check("roll_cnt_saturated", int'(bus.roll_cnt), 255);
        check("spin_len_range_violations", range_bad, 0);
        distinct = 0;
        for (int i = 0; i < 64; i++) if (seen_len[i]) distinct++;
        checks++;
        if (distinct < 2) begin
            failures++;
            $display("FAIL distinct_spin_lengths actual=%0d required=>1", distinct);
        end
        check("scoreboard_drained", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
